// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame state encoding, odd parity helper and default
// timing constants used by both the host transmitter and the receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int INHIBIT_CYCLES_DEF = 1600;    // 100 us at 16 MHz
  localparam int TIMEOUT_CYCLES_DEF = 240000;  // 15 ms at 16 MHz
  localparam int FILTER_LEN_DEF     = 4;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake and status between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, output tx_valid,
                  input tx_ready, input busy, input done, input err);
  modport slave  (input tx_data, input tx_valid,
                  output tx_ready, output busy, output done, output err);
endinterface

// File: rtl/ps2_line_cond.sv
// PS/2 line conditioning: 2-FF synchronizers on clock and data, a
// FILTER_LEN-sample glitch filter on clock, and a falling-edge strobe.
module ps2_line_cond
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt,
  output logic data_sync,
  output logic clk_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_LEN - 1);

  logic          clk_meta_r;
  logic          clk_sync_r;
  logic          data_meta_r;
  logic          data_sync_r;
  logic          clk_filt_r;
  logic          clk_filt_d_r;
  logic [CW-1:0] filt_cnt_r;

  // Synchronizers idle high, matching released open-drain lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
    end
  end

  // A clock level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
      filt_cnt_r   <= '0;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r == clk_filt_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FILT_LAST) begin
        clk_filt_r <= clk_sync_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + CW'(1);
      end
    end
  end

  assign clk_filt  = clk_filt_r;
  assign data_sync = data_sync_r;
  assign clk_fall  = clk_filt_d_r & ~clk_filt_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, 10 bits, ACK).
// Optional macro PS2_TX_RETRY_EN: retry the frame once after a NACK or timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic clk_filt_s;
  logic data_sync_s;
  logic clk_fall_s;

  ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_line_cond (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_filt  (clk_filt_s),
    .data_sync (data_sync_s),
    .clk_fall  (clk_fall_s)
  );

  ps2_state_e    state_r, state_n;
  logic [9:0]    frame_r, frame_n;     // {stop, parity, data}; kept intact for a retry
  logic [3:0]    bit_r, bit_n;
  logic [IW-1:0] inh_r, inh_n;
  logic [TW-1:0] to_r, to_n;
  logic          ack_r, ack_n;
  logic          clk_oe_r, clk_oe_n;
  logic          data_oe_r, data_oe_n;
  logic          done_r, done_n;
  logic          err_r, err_n;
  logic          ready_r, ready_n;
  logic          busy_r, busy_n;
  logic          active_s;
  logic          fail_s;
`ifdef PS2_TX_RETRY_EN
  logic          retry_r, retry_n;
`endif

  assign active_s = (state_r == ST_REQUEST) || (state_r == ST_SHIFT) ||
                    (state_r == ST_ACK)     || (state_r == ST_WAIT_IDLE);

  // Next state and next registered outputs.
  always_comb begin
    state_n   = state_r;
    frame_n   = frame_r;
    bit_n     = bit_r;
    inh_n     = inh_r;
    to_n      = to_r;
    ack_n     = ack_r;
    clk_oe_n  = 1'b0;
    data_oe_n = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    fail_s    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n   = retry_r;
`endif
    if (active_s) begin
      to_n = to_r + TW'(1);
    end else begin
      to_n = to_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (tx.tx_valid && ready_r) begin
          frame_n   = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          state_n   = ST_INHIBIT;
          inh_n     = '0;
          clk_oe_n  = 1'b1;
          data_oe_n = (INH_LAST == '0);
`ifdef PS2_TX_RETRY_EN
          retry_n   = 1'b0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (inh_r == INH_LAST) begin
          state_n   = ST_REQUEST;
          data_oe_n = 1'b1;
          to_n      = '0;
        end else begin
          inh_n     = inh_r + IW'(1);
          clk_oe_n  = 1'b1;
          data_oe_n = ((inh_r + IW'(1)) == INH_LAST);
        end
      end
      ST_REQUEST: begin
        state_n   = ST_SHIFT;
        bit_n     = 4'd0;
        data_oe_n = 1'b1;
      end
      ST_SHIFT: begin
        if (clk_fall_s) begin
          data_oe_n = ~frame_r[bit_r];
          if (bit_r == 4'd9) begin
            state_n = ST_ACK;
          end else begin
            bit_n = bit_r + 4'd1;
          end
        end else begin
          data_oe_n = data_oe_r;
        end
      end
      ST_ACK: begin
        if (clk_fall_s) begin
          ack_n   = ~data_sync_s;
          state_n = ST_WAIT_IDLE;
        end else begin
          state_n = ST_ACK;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_filt_s && data_sync_s) begin
          if (ack_r) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            fail_s = 1'b1;
          end
        end else begin
          state_n = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (active_s && (to_r == TO_LAST)) begin
      fail_s = 1'b1;
    end else begin
      fail_s = fail_s;
    end

    // A failure releases both lines; with retry enabled the first one re-inhibits instead.
    if (fail_s) begin
      done_n    = 1'b0;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      state_n   = ST_IDLE;
      err_n     = 1'b1;
`ifdef PS2_TX_RETRY_EN
      if (!retry_r) begin
        retry_n   = 1'b1;
        state_n   = ST_INHIBIT;
        inh_n     = '0;
        clk_oe_n  = 1'b1;
        data_oe_n = (INH_LAST == '0);
        err_n     = 1'b0;
      end else begin
        retry_n   = retry_r;
      end
`endif
    end else begin
      err_n = 1'b0;
    end

    ready_n = (state_n == ST_IDLE);
    busy_n  = ~ready_n;
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      frame_r   <= '0;
      bit_r     <= 4'd0;
      inh_r     <= '0;
      to_r      <= '0;
      ack_r     <= 1'b0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_r   <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      frame_r   <= frame_n;
      bit_r     <= bit_n;
      inh_r     <= inh_n;
      to_r      <= to_n;
      ack_r     <= ack_n;
      clk_oe_r  <= clk_oe_n;
      data_oe_r <= data_oe_n;
      done_r    <= done_n;
      err_r     <= err_n;
      ready_r   <= ready_n;
      busy_r    <= busy_n;
`ifdef PS2_TX_RETRY_EN
      retry_r   <= retry_n;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign tx.tx_ready = ready_r;
  assign tx.busy     = busy_r;
  assign tx.done     = done_r;
  assign tx.err      = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a simple PS/2 device model clocks frames out,
// records the wire bits and answers ACK/NACK; results are checked against hand values.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TO  = 1500;
  localparam int FL  = 4;
  localparam int H   = 20;   // device clock half period in system clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic ps2_clk_pin;
  logic ps2_data_pin;

  assign ps2_clk_pin  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data_pin = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (tx_if),
    .ps2_clk_i  (ps2_clk_pin),
    .ps2_data_i (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_if.done) done_cnt <= done_cnt + 1;
    if (tx_if.err) err_cnt <= err_cnt + 1;
    if (tx_if.done && tx_if.err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!tx_if.tx_ready && w < 3000) begin
      step(1);
      w++;
    end
    chk("ready_wait", tx_if.tx_ready, 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    step(1);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_request(output bit ok);
    int w = 0;
    while (!ps2_clk_oe && w < 5000) begin step(1); w++; end
    w = 0;
    while (ps2_clk_oe && w < 5000) begin step(1); w++; end
    ok = !ps2_clk_oe && ps2_data_oe;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!tx_if.tx_ready && w < 5000) begin step(1); w++; end
    chk("idle_wait", tx_if.tx_ready, 1);
    step(3);
  endtask

  // Device side of one frame; cut > 0 stops right after that rising edge.
  task automatic dev_frame(input bit nack, input bit glitch, input int cut,
                           output logic [10:0] bits);
    bit ok;
    wait_request(ok);
    chk("request_seen", ok, 1);
    bits = '0;
    bits[0] = ps2_data_pin;
    step(10);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      step(H);
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = ps2_data_pin;
      if (k == 10 && !nack) dev_data = 1'b0;
      if (k == 11) dev_data = 1'b1;
      if (cut != 0 && k == cut) return;
      if (glitch && k >= 2 && k <= 9) begin
        step(8);
        dev_clk = 1'b0;
        step(2);
        dev_clk = 1'b1;
        step(H - 10);
      end else begin
        step(H);
      end
    end
  endtask

  logic [10:0] bits;
  int d0, e0, t0, w;
  bit ok;

  initial begin
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    step(3);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_busy", tx_if.busy, 0);
    rst = 1'b0;
    step(1);
    chk("rst_ready", tx_if.tx_ready, 1);
    chk("rst_done", tx_if.done, 0);
    chk("rst_err", tx_if.err, 0);
    chk("rst_data_oe", ps2_data_oe, 0);

    // 0xF4: expected wire {stop=1, parity=0, F4, start=0} = 11'h5E8
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    chk("f4_busy", tx_if.busy, 1);
    chk("f4_ready_low", tx_if.tx_ready, 0);
    dev_frame(1'b0, 1'b0, 0, bits);
    wait_idle();
    chk("f4_bits", bits, 11'h5E8);
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_err", err_cnt - e0, 0);
    chk("f4_lines", {ps2_clk_oe, ps2_data_oe}, 0);

    // 0x00 then 0xFF (parity 1 both): 11'h600, 11'h7FE; a 0xAA pulse while busy is dropped
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    step(5);
    tx_if.tx_data  = 8'hAA;
    tx_if.tx_valid = 1'b1;
    step(1);
    tx_if.tx_valid = 1'b0;
    dev_frame(1'b0, 1'b0, 0, bits);
    chk("b00_bits", bits, 11'h600);
    wait_idle();
    send(8'hFF);
    dev_frame(1'b0, 1'b0, 0, bits);
    chk("bff_bits", bits, 11'h7FE);
    wait_idle();
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_err", err_cnt - e0, 0);
    step(200);
    chk("no_queued", tx_if.busy, 0);

    // 0xED NACKed: 11'h7DA on the wire, err only
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    dev_frame(1'b1, 1'b0, 0, bits);
    chk("ed_bits", bits, 11'h7DA);
`ifdef PS2_TX_RETRY_EN
    chk("ed_retry_busy", tx_if.busy, 1);
    dev_frame(1'b1, 1'b0, 0, bits);
    chk("ed_retry_bits", bits, 11'h7DA);
`endif
    wait_idle();
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_done", done_cnt - d0, 0);
    chk("nack_lines", {ps2_clk_oe, ps2_data_oe}, 0);

    // Silent device: err exactly TO cycles after clock release
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    wait_request(ok);
`ifdef PS2_TX_RETRY_EN
    wait_request(ok);
`endif
    chk("to_request", ok, 1);
    t0 = cyc;
    w = 0;
    while (!tx_if.err && w < 3 * TO) begin step(1); w++; end
    chk("timeout_cycles", cyc - t0, TO);
    step(3);
    chk("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_done", done_cnt - d0, 0);

    // Reset mid-SHIFT after bit 4, then a clean 0xF4
    send(8'hF4);
    dev_frame(1'b0, 1'b0, 4, bits);
    rst = 1'b1;
    step(1);
    chk("midrst_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("midrst_busy", tx_if.busy, 0);
    rst = 1'b0;
    step(2);
    chk("midrst_ready", tx_if.tx_ready, 1);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_frame(1'b0, 1'b0, 0, bits);
    wait_idle();
    chk("postrst_bits", bits, 11'h5E8);
    chk("postrst_done", done_cnt - d0, 1);
    chk("postrst_err", err_cnt - e0, 0);

    // 2-cycle clock glitches must not advance the bit counter
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_frame(1'b0, 1'b1, 0, bits);
    wait_idle();
    chk("glitch_bits", bits, 11'h5E8);
    chk("glitch_done", done_cnt - d0, 1);
    chk("glitch_err", err_cnt - e0, 0);

    chk("done_err_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
